// File: rtl/jk_pkg.sv
// Shared types for the JK register bank: operating-mode encoding and its width.
package jk_pkg;

  localparam int JK_MODE_W = 2;

  typedef enum logic [JK_MODE_W-1:0] {
    JK_MODE_JK = 2'b00,
    JK_MODE_T  = 2'b01,
    JK_MODE_UP = 2'b10,
    JK_MODE_DN = 2'b11
  } jk_mode_t;

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop bit with enable, synchronous parallel load and synchronous reset.
// q and qn are both registered so qn never lags q by a gate delay.
module jk_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic j,
  input  logic k,
  input  logic load,
  input  logic load_val,
  output logic q,
  output logic qn
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q  <= RST_VAL;
      qn <= ~RST_VAL;
    end else if (en) begin
      if (load) begin
        q  <= load_val;
        qn <= ~load_val;
      end else begin
        case ({j, k})
          2'b01: begin
            q  <= 1'b0;
            qn <= 1'b1;
          end
          2'b10: begin
            q  <= 1'b1;
            qn <= 1'b0;
          end
          2'b11: begin
            q  <= ~q;
            qn <= ~qn;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK cells usable as a JK register, T register or a synchronous
// up/down counter with a programmable terminal value.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int                 WIDTH   = 8,
  parameter longint unsigned    MAX_CNT = (64'd1 << WIDTH) - 64'd1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [JK_MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]     j,
  input  logic [WIDTH-1:0]     k,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qn,
  output logic                 tc,
  output logic                 wrap
);

  localparam logic [WIDTH-1:0] MAX_V = MAX_CNT[WIDTH-1:0];

  jk_mode_t         mode_e;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic             acc_up;
  logic             acc_dn;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic [WIDTH-1:0] load_val;
  logic             load;

  assign mode_e = jk_mode_t'(mode);

  // Synchronous counter toggle terms: bit i flips when all lower bits are 1 (up)
  // or all lower bits are 0 (down, i.e. all lower qn bits are 1).
  always_comb begin
    acc_up = 1'b1;
    acc_dn = 1'b1;
    up_t   = '0;
    dn_t   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = acc_up;
      dn_t[i] = acc_dn;
      acc_up  = acc_up & q[i];
      acc_dn  = acc_dn & qn[i];
    end
  end

  always_comb begin
    tc = 1'b0;
    case (mode_e)
      JK_MODE_UP: tc = (q >= MAX_V);
      JK_MODE_DN: tc = (q == '0);
      default:    tc = 1'b0;
    endcase
  end

  // At the terminal value the toggle path is overridden by a parallel load.
  assign load = mode[1] & tc;

  always_comb begin
    cell_j   = j;
    cell_k   = k;
    load_val = '0;
    case (mode_e)
      JK_MODE_T: cell_k = j;
      JK_MODE_UP: begin
        cell_j = up_t;
        cell_k = up_t;
      end
      JK_MODE_DN: begin
        cell_j   = dn_t;
        cell_k   = dn_t;
        load_val = MAX_V;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RST_VAL (RST_VAL[i])
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .j        (cell_j[i]),
      .k        (cell_k[i]),
      .load     (load),
      .load_val (load_val[i]),
      .q        (q[i]),
      .qn       (qn[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) wrap <= 1'b0;
    else       wrap <= en & load;
  end

endmodule
